// File: rtl/maintenance_sequencer.sv
// Maintenance session sequencer: edge-detects the request M, runs one
// session at a time under a timeout watchdog, counts completed sessions and
// drives the status word (session count, or all-ones while in error).
module maintenance_sequencer #(
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             M,
  input  logic             done,
  input  logic             clr_err,
  output logic [CNT_W-1:0] status,
  output logic             busy,
  output logic             error,
  output logic             en_cont,
  output logic             rst_timer,
  output logic             to
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COMPLETE = 2'd2,
    ERROR    = 2'd3
  } state_t;

  // All-ones is reserved as the error code, so the count tops out one below it.
  localparam logic [CNT_W-1:0] ERR_CODE   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX    = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [7:0]       TIMER_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             m_q;
  logic             primed_q;
  logic [7:0]       timer_q, timer_d;
  logic [CNT_W-1:0] sess_cnt_q, sess_cnt_d;
  logic [CNT_W-1:0] status_q, status_d;
  logic             start;

  // primed_q is clear during the first cycle after reset, so an M that is
  // already high at release is not mistaken for a fresh rising edge.
  assign start  = M & ~m_q & primed_q;

  assign busy   = (state_q == ACTIVE);
  assign error  = (state_q == ERROR);
  assign status = status_q;

  // Next-state, timer, session count and the Mealy strobes.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    sess_cnt_d = sess_cnt_q;
    en_cont    = 1'b0;
    rst_timer  = 1'b0;
    to         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACTIVE;
          rst_timer = 1'b1;
          timer_d   = 8'd0;
        end
      end
      ACTIVE: begin
        // done has priority over a timeout detected in the same cycle.
        if (done) begin
          state_d = COMPLETE;
          en_cont = 1'b1;
          if (sess_cnt_q != CNT_MAX) begin
            sess_cnt_d = sess_cnt_q + 1'b1;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d = ERROR;
          to      = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      COMPLETE: begin
        if (!M) begin
          state_d = IDLE;
        end
      end
      ERROR: begin
        if (clr_err && !M) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    status_d = (state_d == ERROR) ? ERR_CODE : sess_cnt_d;
  end

  // State registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      m_q        <= 1'b0;
      primed_q   <= 1'b0;
      timer_q    <= 8'd0;
      sess_cnt_q <= '0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= M;
      primed_q   <= 1'b1;
      timer_q    <= timer_d;
      sess_cnt_q <= sess_cnt_d;
      status_q   <= status_d;
    end
  end

endmodule

// File: tb/tb_maintenance_sequencer.sv
// Self-checking bench for maintenance_sequencer. Expected status values are
// queued when a session outcome is decided by the stimulus and popped when
// the DUT fires en_cont or to; direct checks cover strobes and state flags.
module tb_maintenance_sequencer;

  localparam int TIMEOUT = 200;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             M;
  logic             done;
  logic             clr_err;
  logic [CNT_W-1:0] status;
  logic             busy;
  logic             error;
  logic             en_cont;
  logic             rst_timer;
  logic             to;

  int               err_cnt = 0;
  int               chk_cnt = 0;
  logic [7:0]       sb_q[$];
  logic [7:0]       exp_count;
  logic             pop_pending = 1'b0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  maintenance_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .M         (M),
    .done      (done),
    .clr_err   (clr_err),
    .status    (status),
    .busy      (busy),
    .error     (error),
    .en_cont   (en_cont),
    .rst_timer (rst_timer),
    .to        (to)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    chk_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives the three operator inputs together.
  task automatic applyStimulus(input logic m_in, input logic done_in, input logic clr_in);
    M       = m_in;
    done    = done_in;
    clr_err = clr_in;
  endtask

  // Advances to just after the next rising edge, where inputs are changed.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one cycle after a completion/timeout strobe, the
  // status register must show the next queued expectation. It also checks
  // that the error code appears in status exactly when error is set.
  always @(negedge clk) begin
    if (rst) begin
      pop_pending = 1'b0;
    end else begin
      checkOutput("status_ff_iff_error", 32'(status == 8'hFF), 32'(error));
      if (pop_pending) begin
        checkOutput("sb_nonempty", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          checkOutput("sb_status", 32'(status), 32'(sb_q.pop_front()));
        end
      end
      pop_pending = en_cont | to;
    end
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    exp_count = 8'd0;
    #3;
    checkOutput("rst_status",    32'(status),    0);
    checkOutput("rst_busy",      32'(busy),      0);
    checkOutput("rst_error",     32'(error),     0);
    checkOutput("rst_en_cont",   32'(en_cont),   0);
    checkOutput("rst_rst_timer", 32'(rst_timer), 0);
    checkOutput("rst_to",        32'(to),        0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    nextCycle();
    nextCycle();

    // Normal session: done on the fifth ACTIVE cycle, then M held high.
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t1_rst_timer", 32'(rst_timer), 1);
    checkOutput("t1_idle_busy", 32'(busy), 0);
    nextCycle();
    for (int n = 1; n <= 5; n++) begin
      if (n == 5) begin
        applyStimulus(1'b1, 1'b1, 1'b0);
        exp_count++;
        sb_q.push_back(exp_count);
      end
      @(negedge clk);
      checkOutput("t1_busy", 32'(busy), 1);
      checkOutput("t1_en_cont", 32'(en_cont), 32'(n == 5));
      checkOutput("t1_rst_timer_active", 32'(rst_timer), 0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checkOutput("t1_hold_busy", 32'(busy), 0);
      checkOutput("t1_hold_rst_timer", 32'(rst_timer), 0);
      checkOutput("t1_hold_status", 32'(status), 32'(exp_count));
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();

    // Timeout session: to fires on the TIMEOUT-th ACTIVE cycle.
    applyStimulus(1'b1, 1'b0, 1'b0);
    sb_q.push_back(8'hFF);
    @(negedge clk);
    checkOutput("t2_rst_timer", 32'(rst_timer), 1);
    nextCycle();
    for (int n = 1; n <= TIMEOUT; n++) begin
      @(negedge clk);
      checkOutput("t2_busy", 32'(busy), 1);
      checkOutput("t2_to", 32'(to), 32'(n == TIMEOUT));
      nextCycle();
    end
    @(negedge clk);
    checkOutput("t2_error", 32'(error), 1);
    checkOutput("t2_busy_off", 32'(busy), 0);
    checkOutput("t2_status_ff", 32'(status), 32'hFF);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checkOutput("t2_clr_ignored", 32'(error), 1);
      checkOutput("t2_err_rst_timer", 32'(rst_timer), 0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t2_pulse_rst_timer", 32'(rst_timer), 0);
    checkOutput("t2_pulse_en_cont", 32'(en_cont), 0);
    checkOutput("t2_pulse_error", 32'(error), 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t2_error_until_edge", 32'(error), 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t2_cleared", 32'(error), 0);
    checkOutput("t2_status_restored", 32'(status), 32'(exp_count));
    nextCycle();

    // done on the same cycle the timeout would fire: completion wins.
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t3_rst_timer", 32'(rst_timer), 1);
    nextCycle();
    for (int n = 1; n <= TIMEOUT; n++) begin
      if (n == TIMEOUT) begin
        applyStimulus(1'b1, 1'b1, 1'b0);
        exp_count++;
        sb_q.push_back(exp_count);
      end
      @(negedge clk);
      checkOutput("t3_en_cont", 32'(en_cont), 32'(n == TIMEOUT));
      checkOutput("t3_to", 32'(to), 0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t3_error", 32'(error), 0);
    checkOutput("t3_busy", 32'(busy), 0);
    checkOutput("t3_status", 32'(status), 32'(exp_count));
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();

    // 255 back-to-back short sessions: the count saturates below the error code.
    for (int s = 0; s < 255; s++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (exp_count != 8'hFE) exp_count++;
      sb_q.push_back(exp_count);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("t4_status_sat", 32'(status), 32'hFE);
    checkOutput("t4_error", 32'(error), 0);
    nextCycle();

    // Asynchronous reset in the middle of ACTIVE, with M held through release.
    applyStimulus(1'b1, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    nextCycle();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_status", 32'(status), 0);
    checkOutput("t5_busy", 32'(busy), 0);
    checkOutput("t5_error", 32'(error), 0);
    checkOutput("t5_en_cont", 32'(en_cont), 0);
    checkOutput("t5_rst_timer", 32'(rst_timer), 0);
    checkOutput("t5_to", 32'(to), 0);
    exp_count = 8'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_release_rst_timer", 32'(rst_timer), 0);
    nextCycle();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checkOutput("t5_held_busy", 32'(busy), 0);
      checkOutput("t5_held_rst_timer", 32'(rst_timer), 0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t5_restart_rst_timer", 32'(rst_timer), 1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0);
    exp_count++;
    sb_q.push_back(exp_count);
    @(negedge clk);
    checkOutput("t5_en_cont", 32'(en_cont), 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();

    checkOutput("sb_empty", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
